// File: rtl/map_pkg.sv
// Shared types and constants for the mapper-select sequencer.
// Launcher control bits, config register addresses, CPU vectors and FSM states.
package map_pkg;

    typedef struct packed {
        logic ingame_menu;
        logic restore_app;
        logic start_app;
        logic buffer_num;
    } launcher_ctrl_t;

    localparam logic [3:0] REG_MAPPER   = 4'd0;
    localparam logic [3:0] REG_LAUNCHER = 4'd1;

    localparam logic [15:0] VEC_RESET  = 16'hFFFC;
    localparam logic [15:0] VEC_NMI    = 16'hFFFA;
    localparam logic [15:0] VEC_NMI_HI = 16'hFFFB;
    localparam logic [15:0] VEC_RESUME = 16'hFFEB;

    typedef enum logic [1:0] {IDLE, START, MENU, RESUME} seq_state_e;

    // Pending launcher request with the highest priority decides the hijack.
    function automatic seq_state_e launch_state(input launcher_ctrl_t c);
        if (c.start_app)   return START;
        if (c.restore_app) return RESUME;
        if (c.ingame_menu) return MENU;
        return IDLE;
    endfunction

endpackage

// File: rtl/cdc_toggle_sync.sv
// Multi-stage synchronizer for an asynchronous level with a one-clk edge pulse.
// FALL_ONLY=1 pulses on falling edges only; otherwise any edge (toggle protocol).
module cdc_toggle_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit FALL_ONLY   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_pulse
);

    // SYNC_STAGES metastability stages plus one history stage for edge detect.
    logic [SYNC_STAGES:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-1:0], i_d};
    end

    generate
        if (FALL_ONLY) begin : g_fall
            assign o_pulse = r_sync[SYNC_STAGES] & ~r_sync[SYNC_STAGES-1];
        end else begin : g_any
            assign o_pulse = r_sync[SYNC_STAGES] ^ r_sync[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/map_select_seq.sv
// Mapper selection for N mappers: launcher/game select with vector-fetch hijack,
// CPU-reset detection, config-register CDC, PRG/CHR mask generation and status.
module map_select_seq
    import map_pkg::*;
#(
    parameter int MAP_CNT     = 7,
    parameter int ADDR_BITS   = 23,
    parameter int RST_CYCLES  = 255,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = $clog2(MAP_CNT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 m2,
    input  logic [15:0]          cpu_addr,
    input  logic                 cpu_rw,
    input  logic [15:0]          wr_reg,
    input  logic [3:0]           wr_reg_addr,
    input  logic                 wr_reg_changed,
    input  logic                 launcher_status,
    input  logic [7:0]           joy1,
    output logic [SEL_W-1:0]     select,
    output logic [SEL_W-1:0]     game_select,
    output logic [ADDR_BITS-1:0] prg_mask,
    output logic [ADDR_BITS-1:0] chr_mask,
    output logic [5:0]           map_args,
    output logic [3:0]           launcher_ctrl,
    output logic                 cpu_reset,
    output logic [31:0]          status_reg
);

    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    logic w_m2_fall, w_wr_pulse, w_cpu_reset;

    cdc_toggle_sync #(.SYNC_STAGES(SYNC_STAGES), .FALL_ONLY(1'b1)) u_m2_sync (
        .clk(clk), .reset_n(reset_n), .i_d(m2), .o_pulse(w_m2_fall)
    );

    cdc_toggle_sync #(.SYNC_STAGES(SYNC_STAGES), .FALL_ONLY(1'b0)) u_wr_sync (
        .clk(clk), .reset_n(reset_n), .i_d(wr_reg_changed), .o_pulse(w_wr_pulse)
    );

    logic [CNT_W-1:0]     r_rst_cnt;
    logic [15:0]          r_addr_q;
    logic                 r_rw_q, r_commit;
    logic [8:0]           r_stat_lo;
    seq_state_e           r_state, w_state_nxt;
    logic [SEL_W-1:0]     r_sel, w_sel_nxt, r_game, w_game_nxt;
    logic [ADDR_BITS-1:0] r_prg, w_prg_nxt, r_chr, w_chr_nxt;
    logic [5:0]           r_args, w_args_nxt;
    logic                 r_err, w_err_nxt;
    launcher_ctrl_t       r_ctrl, w_ctrl_nxt, w_ctrl_wr;

    assign w_cpu_reset = (r_rst_cnt == CNT_W'(RST_CYCLES));

    // MAPPER-write decode: exponent -> masks, index -> game mapper.
    logic [4:0]           w_e, w_idx;
    logic                 w_e_ok, w_idx_ok;
    logic [ADDR_BITS-1:0] w_prg_new, w_chr_new;
    logic [SEL_W-1:0]     w_game_new;

    assign w_e        = wr_reg[9:5];
    assign w_idx      = wr_reg[4:0];
    assign w_e_ok     = (int'(w_e) < ADDR_BITS);
    assign w_idx_ok   = (w_idx != 5'd0) && (int'(w_idx) < MAP_CNT);
    assign w_prg_new  = w_e_ok ? ((ADDR_BITS'(1) << w_e) - ADDR_BITS'(1)) : '1;
    assign w_chr_new  = w_e_ok ? (ADDR_BITS'(1) << w_e) : '0;
    assign w_game_new = w_idx_ok ? w_idx[SEL_W-1:0] : '0;
    assign w_ctrl_wr  = launcher_ctrl_t'(wr_reg[3:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_game_nxt  = r_game;
        w_prg_nxt   = r_prg;
        w_chr_nxt   = r_chr;
        w_args_nxt  = r_args;
        w_err_nxt   = r_err;
        w_ctrl_nxt  = r_ctrl;
        if (w_cpu_reset) begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
            w_game_nxt  = '0;
            w_prg_nxt   = '0;
            w_chr_nxt   = '0;
            w_args_nxt  = '0;
            w_ctrl_nxt  = '0;
        end else begin
            if (w_wr_pulse && wr_reg_addr == REG_MAPPER) begin
                w_game_nxt = w_game_new;
                w_prg_nxt  = w_prg_new;
                w_chr_nxt  = w_chr_new;
                w_args_nxt = wr_reg[15:10];
                w_err_nxt  = !(w_e_ok && w_idx_ok);
            end
            // A launcher write overrides any FSM commit landing in the same clk.
            if (w_wr_pulse && wr_reg_addr == REG_LAUNCHER) begin
                w_ctrl_nxt  = w_ctrl_wr;
                w_state_nxt = launch_state(w_ctrl_wr);
            end else if (r_commit && r_rw_q) begin
                case (r_state)
                    START: if (r_addr_q == VEC_RESET) begin
                        w_sel_nxt            = r_game;
                        w_ctrl_nxt.start_app = 1'b0;
                        w_state_nxt          = IDLE;
                    end
                    MENU: if (r_addr_q == VEC_NMI) begin
                        w_sel_nxt = '0;
                    end else if (r_addr_q == VEC_NMI_HI) begin
                        w_ctrl_nxt.ingame_menu = 1'b0;
                        w_state_nxt            = IDLE;
                    end
                    RESUME: if (r_addr_q == VEC_RESUME) begin
                        w_sel_nxt              = r_game;
                        w_ctrl_nxt.restore_app = 1'b0;
                        w_state_nxt            = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_cnt <= '0;
            r_addr_q  <= '0;
            r_rw_q    <= 1'b0;
            r_commit  <= 1'b0;
            r_stat_lo <= '0;
            r_state   <= IDLE;
            r_sel     <= '0;
            r_game    <= '0;
            r_prg     <= '0;
            r_chr     <= '0;
            r_args    <= '0;
            r_err     <= 1'b0;
            r_ctrl    <= '0;
        end else begin
            if (w_m2_fall)         r_rst_cnt <= '0;
            else if (!w_cpu_reset) r_rst_cnt <= r_rst_cnt + 1'b1;
            r_commit <= w_m2_fall;
            if (w_m2_fall) begin
                r_addr_q  <= cpu_addr;
                r_rw_q    <= cpu_rw;
                r_stat_lo <= {launcher_status, joy1};
            end
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_game  <= w_game_nxt;
            r_prg   <= w_prg_nxt;
            r_chr   <= w_chr_nxt;
            r_args  <= w_args_nxt;
            r_err   <= w_err_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    // Live-bus hijack switches the mapper inside the vector fetch itself.
    always_comb begin
        select = r_sel;
        if (r_state == START && cpu_rw && cpu_addr == VEC_RESET)
            select = r_game;
        else if (r_state == MENU && cpu_rw && cpu_addr == VEC_NMI)
            select = '0;
    end

    assign game_select   = r_game;
    assign prg_mask      = r_prg;
    assign chr_mask      = r_chr;
    assign map_args      = r_args;
    assign launcher_ctrl = r_ctrl;
    assign cpu_reset     = w_cpu_reset;
    assign status_reg    = {21'd0, r_err, w_cpu_reset, r_stat_lo};

endmodule

// File: tb/tb_map_select_seq.sv
// Self-checking bench for map_select_seq: config-write table with scoreboard,
// plus hand sequences for reset detection and vector-fetch hijacks.
module tb_map_select_seq;

    logic        clk = 1'b0, reset_n = 1'b0, m2 = 1'b0, cpu_rw = 1'b1;
    logic        wr_reg_changed = 1'b0, launcher_status = 1'b0;
    logic [15:0] cpu_addr = 16'h8000, wr_reg = 16'h0000;
    logic [3:0]  wr_reg_addr = 4'd0;
    logic [7:0]  joy1 = 8'h00;
    logic [2:0]  select, game_select;
    logic [22:0] prg_mask, chr_mask;
    logic [5:0]  map_args;
    logic [3:0]  launcher_ctrl;
    logic        cpu_reset;
    logic [31:0] status_reg;

    map_select_seq dut (
        .clk(clk), .reset_n(reset_n), .m2(m2), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .wr_reg(wr_reg), .wr_reg_addr(wr_reg_addr), .wr_reg_changed(wr_reg_changed),
        .launcher_status(launcher_status), .joy1(joy1), .select(select),
        .game_select(game_select), .prg_mask(prg_mask), .chr_mask(chr_mask),
        .map_args(map_args), .launcher_ctrl(launcher_ctrl), .cpu_reset(cpu_reset),
        .status_reg(status_reg)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic [2:0]  game;
        logic [22:0] prg, chr;
        logic [5:0]  args;
        logic        err;
        logic [3:0]  ctrl;
    } vec_t;

    vec_t tbl[9];
    vec_t sb[$];

    function automatic vec_t mk(input logic [3:0] a, input logic [15:0] d, input logic [2:0] g,
                                input logic [22:0] p, input logic [22:0] c, input logic [5:0] ar,
                                input logic e, input logic [3:0] ct);
        vec_t v;
        v.addr = a; v.data = d; v.game = g; v.prg = p; v.chr = c;
        v.args = ar; v.err = e; v.ctrl = ct;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m2_cycle(input logic [15:0] a, input logic rw);
        cpu_addr = a;
        cpu_rw   = rw;
        m2       = 1'b1;
        tick(4);
        m2 = 1'b0;
        tick(6);
        cpu_addr = 16'h8000;
        cpu_rw   = 1'b1;
        #1;
    endtask

    // Keeps M2 alive, issues one config write, then checks the popped expectation.
    task automatic apply(input vec_t v, input string nm, input bit lat_chk);
        vec_t e;
        m2_cycle(16'h8000, 1'b1);
        sb.push_back(v);
        wr_reg_addr    = v.addr;
        wr_reg         = v.data;
        wr_reg_changed = ~wr_reg_changed;
        if (lat_chk) begin
            tick(2);
            chk({nm, ".early"}, game_select, 0);
            tick(1);
        end else begin
            tick(3);
        end
        e = sb.pop_front();
        chk({nm, ".game"}, game_select, e.game);
        chk({nm, ".prg"},  prg_mask,    e.prg);
        chk({nm, ".chr"},  chr_mask,    e.chr);
        chk({nm, ".args"}, map_args,    e.args);
        chk({nm, ".err"},  status_reg[10], e.err);
        chk({nm, ".ctrl"}, launcher_ctrl, e.ctrl);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(4'd0, 16'h00A9, 3'd0, 23'h00001F, 23'h000020, 6'h00, 1'b1, 4'h0);
        tbl[1] = mk(4'd0, 16'hFFC2, 3'd2, 23'h7FFFFF, 23'h000000, 6'h3F, 1'b1, 4'h0);
        tbl[2] = mk(4'd0, 16'h0006, 3'd6, 23'h000000, 23'h000001, 6'h00, 1'b0, 4'h0);
        tbl[3] = mk(4'd0, 16'h02C1, 3'd1, 23'h3FFFFF, 23'h400000, 6'h00, 1'b0, 4'h0);
        tbl[4] = mk(4'd0, 16'h02E1, 3'd1, 23'h7FFFFF, 23'h000000, 6'h00, 1'b1, 4'h0);
        tbl[5] = mk(4'd0, 16'h0060, 3'd0, 23'h000007, 23'h000008, 6'h00, 1'b1, 4'h0);
        tbl[6] = mk(4'd0, 16'h0067, 3'd0, 23'h000007, 23'h000008, 6'h00, 1'b1, 4'h0);
        tbl[7] = mk(4'd0, 16'h04A3, 3'd3, 23'h00001F, 23'h000020, 6'h01, 1'b0, 4'h0);
        tbl[8] = mk(4'd5, 16'h0001, 3'd3, 23'h00001F, 23'h000020, 6'h01, 1'b0, 4'h0);

        // Reset state and idle-M2 reset detection.
        tick(2);
        chk("rst.select", select, 0);
        chk("rst.game", game_select, 0);
        chk("rst.prg", prg_mask, 0);
        chk("rst.chr", chr_mask, 0);
        chk("rst.args", map_args, 0);
        chk("rst.ctrl", launcher_ctrl, 0);
        chk("rst.cpu_reset", cpu_reset, 0);
        chk("rst.status", status_reg, 0);
        reset_n = 1'b1;
        tick(254);
        chk("idle.254", cpu_reset, 0);
        tick(1);
        chk("idle.255", cpu_reset, 1);
        chk("idle.status", status_reg, 32'h0000_0200);
        m2 = 1'b1;
        tick(4);
        m2 = 1'b0;
        tick(2);
        chk("m2fall.hold", cpu_reset, 1);
        tick(1);
        chk("m2fall.release", cpu_reset, 0);

        // Status low bits load only on M2 fall.
        joy1 = 8'h5A;
        launcher_status = 1'b1;
        m2_cycle(16'h8000, 1'b1);
        chk("status.load", status_reg, 32'h0000_015A);
        joy1 = 8'hFF;
        tick(2);
        chk("status.hold", status_reg[8:0], 9'h15A);

        apply(mk(4'd0, 16'h04A3, 3'd3, 23'h1F, 23'h20, 6'h01, 1'b0, 4'h0), "map04A3", 1'b1);
        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("tbl%0d", i), 1'b0);

        // Start: live hijack on FFFC, then registered commit.
        apply(mk(4'd1, 16'h0002, 3'd3, 23'h1F, 23'h20, 6'h01, 1'b0, 4'b0010), "lstart", 1'b0);
        chk("start.pre", select, 0);
        cpu_addr = 16'hFFFC;
        cpu_rw   = 1'b1;
        #1;
        chk("start.hijack", select, 3);
        m2_cycle(16'hFFFC, 1'b1);
        chk("start.commit", select, 3);
        chk("start.clr", launcher_ctrl, 4'b0000);

        // Menu: writes to FFFA are ignored, reads switch to launcher.
        apply(mk(4'd1, 16'h0008, 3'd3, 23'h1F, 23'h20, 6'h01, 1'b0, 4'b1000), "lmenu", 1'b0);
        cpu_addr = 16'hFFFA;
        cpu_rw   = 1'b0;
        #1;
        chk("menu.wr_live", select, 3);
        m2_cycle(16'hFFFA, 1'b0);
        chk("menu.wr_commit", select, 3);
        cpu_addr = 16'hFFFA;
        cpu_rw   = 1'b1;
        #1;
        chk("menu.hijack", select, 0);
        m2_cycle(16'hFFFA, 1'b1);
        chk("menu.commit", select, 0);
        chk("menu.hold", launcher_ctrl, 4'b1000);
        m2_cycle(16'hFFFB, 1'b1);
        chk("menu.clr", launcher_ctrl, 4'b0000);
        chk("menu.sel", select, 0);

        // Priority: restore_app beats ingame_menu.
        apply(mk(4'd1, 16'h000C, 3'd3, 23'h1F, 23'h20, 6'h01, 1'b0, 4'b1100), "lprio", 1'b0);
        m2_cycle(16'hFFFA, 1'b1);
        m2_cycle(16'hFFEB, 1'b1);
        chk("prio.select", select, 3);
        chk("prio.ctrl", launcher_ctrl, 4'b1000);

        // Mid-op reset: START armed, M2 stops.
        apply(mk(4'd1, 16'h0002, 3'd3, 23'h1F, 23'h20, 6'h01, 1'b0, 4'b0010), "lstart2", 1'b0);
        cpu_addr = 16'hFFFC;
        cpu_rw   = 1'b1;
        tick(260);
        chk("midrst.cpu_reset", cpu_reset, 1);
        chk("midrst.select", select, 0);
        chk("midrst.ctrl", launcher_ctrl, 0);
        chk("midrst.game", game_select, 0);
        chk("midrst.prg", prg_mask, 0);
        chk("midrst.chr", chr_mask, 0);
        chk("midrst.args", map_args, 0);
        wr_reg_addr    = 4'd0;
        wr_reg         = 16'h04A3;
        wr_reg_changed = ~wr_reg_changed;
        tick(5);
        chk("drop.during", game_select, 0);
        cpu_addr = 16'h8000;
        m2 = 1'b1;
        tick(4);
        m2 = 1'b0;
        tick(4);
        chk("drop.release", cpu_reset, 0);
        chk("drop.after", game_select, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
